// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I sequencing controller: Moore FSM with ALU-control and immediate-type decode.
// Compile macro MC_CTRL_ILLEGAL_HALT_EN: undefined opcodes halt the core and raise a sticky flag.
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zeroFlag,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] immSrc,
  output logic [3:0] state_dbg,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_RST_IDLE = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2
  } alu_op_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  state_t  state;
  state_t  state_next;
  alu_op_t alu_op;
  logic [2:0] funct_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RST_IDLE: state_next = S_FETCH;
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
          default:      state_next = S_HALT;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      // jal writes rd = OldPC+4 through the common ALU writeback state
      S_JAL:      state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_RST_IDLE;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    AdrSrc    = 1'b0;
    alu_op    = AOP_ADD;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = AOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = AOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      // Only Mealy term: branch taken resolves from the live ALU zero flag
      S_BEQ: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        alu_op    = AOP_SUB;
        ResultSrc = RES_ALUOUT;
        PCWrite   = zeroFlag;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    funct_ctrl = ALU_ADD;
    case (funct3)
      3'b000:  funct_ctrl = (opcode[5] & funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctrl = ALU_SLT;
      3'b110:  funct_ctrl = ALU_OR;
      3'b111:  funct_ctrl = ALU_AND;
      default: funct_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      AOP_SUB:   ALUControl = ALU_SUB;
      AOP_FUNCT: ALUControl = funct_ctrl;
      default:   ALUControl = ALU_ADD;
    endcase
  end

  // Immediate type follows the opcode in every state except the all-zero idle/halt states
  always_comb begin
    immSrc = 3'b000;
    if (state != S_RST_IDLE && state != S_HALT) begin
      case (opcode)
        OP_SW:   immSrc = 3'b001;
        OP_BEQ:  immSrc = 3'b010;
        OP_JAL:  immSrc = 3'b011;
        default: immSrc = 3'b000;
      endcase
    end
  end

  assign state_dbg = state;

`ifdef MC_CTRL_ILLEGAL_HALT_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          illegal_q <= 1'b0;
    else if (state_next == S_HALT)    illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed scoreboard bench for mc_ctrl_fsm: expected output vectors are queued per
// instruction and compared one per cycle at the falling edge.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zeroFlag;
  logic       PCWrite, RegWrite, MemWrite, IRWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic       AdrSrc;
  logic [2:0] ALUControl, immSrc;
  logic [3:0] state_dbg;
  logic       illegal;

  int passed = 0;
  int total  = 0;

  logic [21:0] exp_q[$];
  logic [21:0] obs;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zeroFlag(zeroFlag), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .AdrSrc(AdrSrc), .ALUControl(ALUControl), .immSrc(immSrc), .state_dbg(state_dbg),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {state_dbg, PCWrite, RegWrite, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, AdrSrc, ALUControl, immSrc, illegal};

  // {state, PCWrite, RegWrite, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ALUControl, immSrc, illegal}
  function automatic logic [21:0] ev(input logic [3:0] st, input logic pcw, input logic rw,
                                     input logic mw, input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb, input logic adr,
                                     input logic [2:0] aluc, input logic [2:0] imm, input logic ill);
    return {st, pcw, rw, mw, irw, rs, sa, sb, adr, aluc, imm, ill};
  endfunction

  function automatic logic [21:0] e_fetch(input logic [2:0] imm);
    return ev(4'd1, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 3'b000, imm, 0);
  endfunction
  function automatic logic [21:0] e_decode(input logic [2:0] imm);
    return ev(4'd2, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, imm, 0);
  endfunction
  function automatic logic [21:0] e_aluwb(input logic [2:0] imm);
    return ev(4'd9, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, imm, 0);
  endfunction

  task automatic check(input string tag, input logic [21:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Pops and compares n queued vectors, one per cycle; ends just after the last one.
  task automatic run_seq(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++;
        $error("FAIL %s observed=empty_queue expected=vector", tag);
      end else begin
        check($sformatf("%s[%0d]", tag, k), exp_q.pop_front());
      end
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opcode = op; funct3 = f3; funct7_5 = f75;
  endtask

  task automatic do_lw();
    drive(7'b0000011, 3'b010, 0);
    exp_q.push_back(e_fetch(3'b000));
    exp_q.push_back(e_decode(3'b000));
    exp_q.push_back(ev(4'd3, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b000, 0));
    exp_q.push_back(ev(4'd4, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000, 0));
    exp_q.push_back(ev(4'd5, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 3'b000, 3'b000, 0));
    run_seq("lw", 5);
    @(negedge clk);
  endtask

  task automatic do_sw();
    drive(7'b0100011, 3'b010, 0);
    exp_q.push_back(e_fetch(3'b001));
    exp_q.push_back(e_decode(3'b001));
    exp_q.push_back(ev(4'd3, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b001, 0));
    exp_q.push_back(ev(4'd6, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b001, 0));
    run_seq("sw", 4);
    @(negedge clk);
  endtask

  task automatic do_alu(input string tag, input logic is_r, input logic [2:0] f3,
                        input logic f75, input logic [2:0] aluc);
    drive(is_r ? 7'b0110011 : 7'b0010011, f3, f75);
    exp_q.push_back(e_fetch(3'b000));
    exp_q.push_back(e_decode(3'b000));
    if (is_r) exp_q.push_back(ev(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, aluc, 3'b000, 0));
    else      exp_q.push_back(ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, aluc, 3'b000, 0));
    exp_q.push_back(e_aluwb(3'b000));
    run_seq(tag, 4);
    @(negedge clk);
  endtask

  task automatic do_beq(input logic zf);
    drive(7'b1100011, 3'b000, 0);
    zeroFlag = zf;
    exp_q.push_back(e_fetch(3'b010));
    exp_q.push_back(e_decode(3'b010));
    exp_q.push_back(ev(4'd10, zf, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 3'b010, 0));
    run_seq(zf ? "beq_taken" : "beq_not_taken", 3);
    zeroFlag = ~zf;
    exp_q.push_back(ev(4'd10, ~zf, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 3'b010, 0));
    run_seq("beq_zero_flip", 1);
    zeroFlag = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_jal();
    drive(7'b1101111, 3'b000, 0);
    exp_q.push_back(e_fetch(3'b011));
    exp_q.push_back(e_decode(3'b011));
    exp_q.push_back(ev(4'd11, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 3'b011, 0));
    exp_q.push_back(e_aluwb(3'b011));
    run_seq("jal", 4);
    @(negedge clk);
  endtask

  // Asserts reset asynchronously mid-cycle, holds across an edge, releases; ends in FETCH.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_assert"}, 22'd0);
    @(negedge clk);
    #1;
    check({tag, "_hold"}, 22'd0);
    rst = 1'b0;
    #1;
    check({tag, "_release"}, 22'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(7'b0000000, 3'b000, 0);
    zeroFlag = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold", 22'd0);
    rst = 1'b0;
    #1;
    check("reset_release", 22'd0);
    @(negedge clk);

    do_lw();
    do_sw();
    do_alu("r_sub", 1, 3'b000, 1, 3'b001);
    do_alu("r_add", 1, 3'b000, 0, 3'b000);
    do_alu("r_slt", 1, 3'b010, 0, 3'b101);
    do_alu("r_or",  1, 3'b110, 0, 3'b011);
    do_alu("r_and", 1, 3'b111, 0, 3'b010);
    do_alu("r_xor", 1, 3'b100, 0, 3'b000);
    do_alu("addi_f7", 0, 3'b000, 1, 3'b000);
    do_alu("slti",  0, 3'b010, 0, 3'b101);
    do_beq(1'b1);
    do_beq(1'b0);
    do_jal();

    drive(7'b1111111, 3'b000, 0);
    exp_q.push_back(e_fetch(3'b000));
    exp_q.push_back(e_decode(3'b000));
`ifdef MC_CTRL_ILLEGAL_HALT_EN
    for (int i = 0; i < 3; i++)
      exp_q.push_back(ev(4'd12, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 1));
    run_seq("illegal_halt", 5);
    @(negedge clk);
    drive(7'b0000011, 3'b010, 0);
    exp_q.push_back(ev(4'd12, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 3'b000, 1));
    run_seq("halt_sticky", 1);
    do_reset("halt_reset");
`else
    run_seq("illegal_nop", 2);
    @(negedge clk);
`endif
    do_jal();

    // Abort a load in MEMREAD: nothing may be written after reset asserts
    drive(7'b0000011, 3'b010, 0);
    exp_q.push_back(e_fetch(3'b000));
    exp_q.push_back(e_decode(3'b000));
    exp_q.push_back(ev(4'd3, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 3'b000, 0));
    exp_q.push_back(ev(4'd4, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 3'b000, 0));
    run_seq("lw_abort", 4);
    #1;
    do_reset("mid_reset");
    do_sw();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
